// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Holds the FSM state encoding, the error codes reported on o_err_code,
// and a helper that identifies the in-frame states.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_RUN  = 3'd5
  } boot_state_t;

  localparam logic [1:0] ERR_TOO_LONG = 2'd1;
  localparam logic [1:0] ERR_CSUM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // The timeout counter only runs while a frame is being received.
  function automatic logic in_frame(boot_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte stream in from rx_uart and word write bus out to program memory.
// Ports: rx_valid/rx_data (one-cycle byte strobe), wr_valid/wr_addr/wr_data
// (one-cycle word write). No backpressure on either side.
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master: byte source and memory sink (cputest wrapper / testbench)
  modport master (output rx_valid, rx_data, input wr_valid, wr_addr, wr_data);
  // slave: the boot loader itself
  modport slave  (input rx_valid, rx_data, output wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/uart_boot_loader_word_packer.sv
// Packs four bytes little-endian into a word and keeps an 8-bit running sum.
// Latency: word_done/word_out are registered, valid the cycle after the 4th byte.
// Backpressure: none; accepts one byte per cycle.
// Ports: clk, rst (sync, active-high), clear (restart lane count and sum),
//        byte_in/byte_valid in; word_out, word_done, lane (bytes held), csum out.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_done,
  output logic [1:0]  lane,
  output logic [7:0]  csum
);

  // Bytes 0..2 of the word in progress; byte 0 ends up in [7:0].
  logic [23:0] low_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      low_bytes <= '0;
      word_out  <= '0;
      word_done <= 1'b0;
      lane      <= 2'd0;
      csum      <= 8'd0;
    end else begin
      word_done <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
        csum <= 8'd0;
      end else if (byte_valid) begin
        csum <= csum + byte_in;
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          word_out  <= {byte_in, low_bytes};
          word_done <= 1'b1;
        end else begin
          // Shift right so earlier bytes settle into lower lanes.
          low_bytes <= {byte_in, low_bytes[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Framed, checksummed UART boot loader: SYNC, LEN lo/hi (words), 4*N data bytes, CSUM.
// Latency: a word is written the cycle after its 4th byte; o_cpu_running rises the
// cycle after a matching CSUM byte. Backpressure: none, one byte per cycle accepted.
// Ports: clk, i_reset (sync, active-high), bus (rx bytes in, word writes out),
//        o_cpu_running, o_err (1-cycle pulse), o_err_code (held), o_words_loaded.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned       MAX_WORDS      = 4096,
  parameter logic [7:0]        SYNC_BYTE      = 8'hA5,
  parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               i_reset,
  uart_boot_loader_if.slave  bus,
  output logic               o_cpu_running,
  output logic               o_err,
  output logic [1:0]         o_err_code,
  output logic [15:0]        o_words_loaded
);

  // Counter holds idle cycles since the last byte; expiry is on the
  // TIMEOUT_CYCLES-th idle cycle, i.e. when it already reads TIMEOUT_CYCLES-1.
  localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       MAX_LEN  = 17'(MAX_WORDS);

  boot_state_t       state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] wr_addr_q;

  logic [15:0]       len_in;
  logic [15:0]       words_next;
  logic [ADDR_W-1:0] word_off;
  logic              sync_seen;
  logic              data_byte;

  logic [31:0]       word_out;
  logic              word_done;
  logic [1:0]        lane;
  logic [7:0]        csum;

  assign len_in     = {bus.rx_data, len_lo};
  assign words_next = o_words_loaded + 16'd1;
  // o_words_loaded doubles as the index of the word being assembled.
  assign word_off   = ADDR_W'(o_words_loaded) << 2;
  assign sync_seen  = (state == ST_IDLE) && bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign data_byte  = (state == ST_DATA) && bus.rx_valid;

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (i_reset),
    .clear      (sync_seen),
    .byte_in    (bus.rx_data),
    .byte_valid (data_byte),
    .word_out   (word_out),
    .word_done  (word_done),
    .lane       (lane),
    .csum       (csum)
  );

  assign bus.wr_valid = word_done;
  assign bus.wr_data  = word_out;
  assign bus.wr_addr  = wr_addr_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      len_lo         <= 8'd0;
      len            <= 16'd0;
      tmo_cnt        <= '0;
      wr_addr_q      <= '0;
      o_cpu_running  <= 1'b0;
      o_err          <= 1'b0;
      o_err_code     <= 2'd0;
      o_words_loaded <= 16'd0;
    end else begin
      o_err <= 1'b0;

      // Timeout: an arriving byte always wins over expiry in the same cycle.
      if (in_frame(state)) begin
        if (bus.rx_valid) begin
          tmo_cnt <= '0;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_cnt    <= '0;
          state      <= ST_IDLE;
          o_err      <= 1'b1;
          o_err_code <= ERR_TIMEOUT;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state          <= ST_LEN0;
              o_words_loaded <= 16'd0;
            end
          end
          ST_LEN0: begin
            len_lo <= bus.rx_data;
            state  <= ST_LEN1;
          end
          ST_LEN1: begin
            len <= len_in;
            if ({1'b0, len_in} > MAX_LEN) begin
              state      <= ST_IDLE;
              o_err      <= 1'b1;
              o_err_code <= ERR_TOO_LONG;
            end else if (len_in == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            // Address and count are registered here so they line up with
            // the packer's word_done strobe on the following cycle.
            if (lane == 2'd3) begin
              wr_addr_q      <= BASE_ADDR + word_off;
              o_words_loaded <= words_next;
              if (words_next == len) begin
                state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (bus.rx_data == csum) begin
              state         <= ST_RUN;
              o_cpu_running <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              o_err      <= 1'b1;
              o_err_code <= ERR_CSUM;
            end
          end
          default: begin
            // ST_RUN: the image is live; ignore everything until reset.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: two instances (base 0 and base 0xFFFFFFFC),
// both with a 50-cycle timeout. Writes and error pulses are logged on the falling edge.
module tb_uart_boot_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic run_a, err_a, run_b, err_b;
  logic [1:0] code_a, code_b;
  logic [15:0] wl_a, wl_b;

  uart_boot_loader_if #(.ADDR_W(32)) bus_a ();
  uart_boot_loader_if #(.ADDR_W(32)) bus_b ();

  uart_boot_loader #(
    .ADDR_W(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut_a (
    .clk(clk), .i_reset(rst_a), .bus(bus_a),
    .o_cpu_running(run_a), .o_err(err_a), .o_err_code(code_a), .o_words_loaded(wl_a)
  );

  uart_boot_loader #(
    .ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(4096),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut_b (
    .clk(clk), .i_reset(rst_b), .bus(bus_b),
    .o_cpu_running(run_b), .o_err(err_b), .o_err_code(code_b), .o_words_loaded(wl_b)
  );

  int total = 0;
  int bad = 0;

  // Write log entries are {addr, data}.
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  int errs_a = 0;
  int errs_b = 0;

  always @(negedge clk) begin
    if (bus_a.wr_valid === 1'b1) wq_a.push_back({bus_a.wr_addr, bus_a.wr_data});
    if (bus_b.wr_valid === 1'b1) wq_b.push_back({bus_b.wr_addr, bus_b.wr_data});
    if (err_a === 1'b1) errs_a++;
    if (err_b === 1'b1) errs_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wr_a(input int i);
    if (i < wq_a.size()) return wq_a[i];
    return 'x;
  endfunction

  function automatic logic [63:0] wr_b(input int i);
    if (i < wq_b.size()) return wq_b[i];
    return 'x;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to_b, input logic [7:0] b);
    if (to_b) begin
      bus_b.rx_valid = 1'b1;
      bus_b.rx_data  = b;
    end else begin
      bus_a.rx_valid = 1'b1;
      bus_a.rx_data  = b;
    end
    @(posedge clk);
    #1;
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  task automatic send_all(input bit to_b, input bq_t bs);
    foreach (bs[i]) send(to_b, bs[i]);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.rx_valid = 1'b0;
    idle(2);
    rst_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " running"}, {63'd0, run_a}, 64'd0);
    check({tag, " err"}, {62'd0, err_a, bus_a.wr_valid}, 64'd0);
    check({tag, " code/words"}, {46'd0, code_a, wl_a}, 64'd0);
    check({tag, " wr bus"}, {bus_a.wr_addr, bus_a.wr_data}, 64'd0);
  endtask

  bq_t good, frm;
  int wb, eb;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.rx_valid = 1'b0; bus_a.rx_data = 8'h00;
    bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'h00;
    good = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    idle(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_reset_a("reset");

    // 1) good two-word frame
    wb = wq_a.size(); eb = errs_a;
    send_all(0, good);
    idle(2);
    check("t1 nwr", wq_a.size() - wb, 2);
    check("t1 wr0", wr_a(wb), {32'h0000_0000, 32'h4433_2211});
    check("t1 wr1", wr_a(wb + 1), {32'h0000_0004, 32'h8877_6655});
    check("t1 run", {63'd0, run_a}, 64'd1);
    check("t1 noerr", errs_a - eb, 0);
    check("t1 words", {48'd0, wl_a}, 64'd2);

    // 2) bad checksum, then resend the good frame
    reset_a();
    wb = wq_a.size(); eb = errs_a;
    frm = good;
    frm[11] = 8'h65;
    send_all(0, frm);
    idle(2);
    check("t2 nwr", wq_a.size() - wb, 2);
    check("t2 err pulse", errs_a - eb, 1);
    check("t2 code", {62'd0, code_a}, 64'd2);
    check("t2 norun", {63'd0, run_a}, 64'd0);
    check("t2 words kept", {48'd0, wl_a}, 64'd2);
    wb = wq_a.size();
    send_all(0, good);
    idle(2);
    check("t2 resend wr1", wr_a(wb + 1), {32'h0000_0004, 32'h8877_6655});
    check("t2 resend run", {63'd0, run_a}, 64'd1);
    check("t2 code held", {62'd0, code_a}, 64'd2);

    // 3) junk, oversize length, then zero-length frame
    reset_a();
    wb = wq_a.size(); eb = errs_a;
    send_all(0, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h10});
    idle(2);
    check("t3 too long code", {62'd0, code_a}, 64'd1);
    check("t3 err pulse", errs_a - eb, 1);
    check("t3 no writes", wq_a.size() - wb, 0);
    check("t3 norun", {63'd0, run_a}, 64'd0);
    send_all(0, '{8'hA5, 8'h00, 8'h00, 8'h00});
    idle(2);
    check("t3 zero len run", {63'd0, run_a}, 64'd1);
    check("t3 zero len words", {48'd0, wl_a}, 64'd0);

    // 4) timeout: 49 idle cycles is fine, the 50th expires
    reset_a();
    wb = wq_a.size(); eb = errs_a;
    send_all(0, '{8'hA5, 8'h01, 8'h00, 8'h11});
    idle(49);
    @(negedge clk); #1;
    check("t4 no early tmo", errs_a - eb, 0);
    idle(2);
    check("t4 tmo pulse", errs_a - eb, 1);
    check("t4 tmo code", {62'd0, code_a}, 64'd3);
    check("t4 norun", {63'd0, run_a}, 64'd0);
    eb = errs_a;
    send_all(0, '{8'hA5, 8'h01, 8'h00, 8'h11});
    idle(49);
    send_all(0, '{8'h22, 8'h33, 8'h44, 8'hAA});
    idle(2);
    check("t4 byte wins", errs_a - eb, 0);
    check("t4 late run", {63'd0, run_a}, 64'd1);
    check("t4 wr", wr_a(wb), {32'h0000_0000, 32'h4433_2211});

    // 5) reset after the 2nd of 3 data words, then a fresh frame
    reset_a();
    wb = wq_a.size();
    send_all(0, '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88});
    idle(1);
    check("t5 pre-reset words", {48'd0, wl_a}, 64'd2);
    reset_a();
    check_reset_a("t5 reset");
    wb = wq_a.size();
    send_all(0, good);
    idle(2);
    check("t5 wr0", wr_a(wb), {32'h0000_0000, 32'h4433_2211});
    check("t5 wr1", wr_a(wb + 1), {32'h0000_0004, 32'h8877_6655});
    check("t5 run", {63'd0, run_a}, 64'd1);

    // 6) frames after RUN are ignored
    wb = wq_a.size(); eb = errs_a;
    send_all(0, '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    idle(2);
    check("t6 no writes", wq_a.size() - wb, 0);
    check("t6 still run", {63'd0, run_a}, 64'd1);
    check("t6 words kept", {48'd0, wl_a}, 64'd2);
    check("t6 noerr", errs_a - eb, 0);

    // 6b) address wrap at the top of the address space
    send_all(1, good);
    idle(2);
    check("t6b nwr", wq_b.size(), 2);
    check("t6b wr0", wr_b(0), {32'hFFFF_FFFC, 32'h4433_2211});
    check("t6b wr1", wr_b(1), {32'h0000_0000, 32'h8877_6655});
    check("t6b run", {63'd0, run_b}, 64'd1);
    check("t6b status", {30'd0, errs_b, code_b, wl_b}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
